// File: rtl/load_store_unit.sv
// Load/store unit between the single-cycle datapath and a big-endian byte-lane data memory.
// One request at a time: latch, issue a word-aligned access, wait a fixed latency, respond.
module load_store_unit #(
  parameter int XLEN        = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misalign,
  output logic            mem_en,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            we_q;
  logic [1:0]      size_q;
  logic            signed_q;
  logic [1:0]      lo_q;

  logic            misaligned;
  logic [3:0]      store_be;
  logic [XLEN-1:0] store_data;

  // Pick the addressed lane(s) of the big-endian word and extend to full width.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [1:0]      size,
                                                  input logic [1:0]      lo,
                                                  input logic            sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = lo[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   load_extend = {{(XLEN-8){sgn & b[7]}}, b};
      2'b01:   load_extend = {{(XLEN-16){sgn & h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    misaligned = 1'b0;
    store_be   = 4'b1111;
    store_data = req_wdata;
    case (req_size)
      2'b00: begin
        store_be   = 4'b1000 >> req_addr[1:0];
        store_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr[0];
        store_be   = req_addr[1] ? 4'b0011 : 4'b1100;
        store_data = {2{req_wdata[15:0]}};
      end
      default: misaligned = (req_addr[1:0] != 2'b00);
    endcase
  end

  assign stall = req_valid & ~resp_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      signed_q      <= 1'b0;
      lo_q          <= 2'b00;
      resp_valid    <= 1'b0;
      resp_misalign <= 1'b0;
      resp_rdata    <= '0;
      mem_en        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= 4'b0000;
      mem_wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            lo_q     <= req_addr[1:0];
            if (misaligned) begin
              state         <= RESP;
              resp_valid    <= 1'b1;
              resp_misalign <= 1'b1;
              resp_rdata    <= '0;
            end else begin
              state     <= ISSUE;
              mem_en    <= 1'b1;
              mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
              mem_wdata <= store_data;
              mem_be    <= req_we ? store_be : 4'b0000;
            end
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_be <= 4'b0000;
          cnt    <= CW'(MEM_LATENCY - 1);
          state  <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            state         <= RESP;
            resp_valid    <= 1'b1;
            resp_misalign <= 1'b0;
            // Stores wait the same latency for uniform timing but return zero.
            resp_rdata    <= we_q ? '0 : load_extend(mem_rdata, size_q, lo_q, signed_q);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: three load_store_unit instances (latency 2, 1, 3) share a byte-addressed
// reference memory model; directed scenarios followed by randomized transactions.
module tb_load_store_unit;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [N-1:0] req_valid, req_we, req_signed, stall, resp_valid, resp_misalign, mem_en;
  logic [1:0]   req_size   [N];
  logic [31:0]  req_addr   [N];
  logic [31:0]  req_wdata  [N];
  logic [31:0]  resp_rdata [N];
  logic [31:0]  mem_addr   [N];
  logic [31:0]  mem_wdata  [N];
  logic [31:0]  mem_rdata  [N];
  logic [3:0]   mem_be     [N];

  int vectors     = 0;
  int miscompares = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    load_store_unit #(
      .XLEN(32),
      .MEM_LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid[g]),
      .req_we       (req_we[g]),
      .req_size     (req_size[g]),
      .req_signed   (req_signed[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .stall        (stall[g]),
      .resp_valid   (resp_valid[g]),
      .resp_rdata   (resp_rdata[g]),
      .resp_misalign(resp_misalign[g]),
      .mem_en       (mem_en[g]),
      .mem_addr     (mem_addr[g]),
      .mem_be       (mem_be[g]),
      .mem_wdata    (mem_wdata[g]),
      .mem_rdata    (mem_rdata[g])
    );
  end

  // Physical memory seen by the DUTs: 16 words at 0x100; read data is valid only in the
  // single cycle exactly MEM_LATENCY edges after the mem_en sample, garbage otherwise.
  logic [31:0] mem   [16];
  int          age   [N];
  logic [3:0]  paddr [N];

  initial for (int k = 0; k < N; k++) age[k] = 0;

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (mem_en[k]) begin
        age[k]   <= 1;
        paddr[k] <= mem_addr[k][5:2];
        for (int j = 0; j < 4; j++)
          if (mem_be[k][3-j]) mem[mem_addr[k][5:2]][31-8*j -: 8] <= mem_wdata[k][31-8*j -: 8];
      end else if (age[k] != 0 && age[k] < 100) begin
        age[k] <= age[k] + 1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++)
      mem_rdata[k] = (age[k] == lat_of(k)) ? mem[paddr[k]] : 32'hDEAD_BEEF;
  end

  // Reference model: plain byte array, address 0x100 + i holds ref_b[i] (big-endian words).
  logic [7:0]  ref_b [64];
  logic [31:0] last_rdata [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete request on instance k, starting in an IDLE cycle (T = the cycle it is driven).
  task automatic txn(input int k, input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] got_rdata, output logic [31:0] got_addr,
                     output logic [31:0] got_wdata, output logic [3:0] got_be);
    int          a, nb, exp_resp, resp_at, issue_at, issues, stall_low;
    bit          mis;
    logic [31:0] v, exp_wdata;
    logic [3:0]  exp_be;
    a  = int'(addr) - 32'h100;
    nb = (size == 2'b00) ? 1 : ((size == 2'b01) ? 2 : 4);
    mis = (a % nb) != 0;
    v = '0;
    if (!mis && !we) begin
      for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_b[a+i]);
      if (nb < 4 && sgn && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
    end
    exp_be = 4'b0000;
    if (we) for (int i = 0; i < nb; i++) exp_be[3 - ((a + i) % 4)] = 1'b1;
    exp_wdata = (nb == 1) ? {4{wdata[7:0]}} : ((nb == 2) ? {2{wdata[15:0]}} : wdata);
    exp_resp = mis ? 1 : 2 + lat_of(k);
    resp_at = -1; issue_at = -1; issues = 0; stall_low = 0;
    got_rdata = '0; got_addr = '0; got_wdata = '0; got_be = '0;

    @(negedge clk);
    check("idle_resp_valid", resp_valid[k], 1'b0);
    check("rdata_hold", resp_rdata[k], last_rdata[k]);
    req_we[k] = we; req_size[k] = size; req_signed[k] = sgn;
    req_addr[k] = addr; req_wdata[k] = wdata; req_valid[k] = 1'b1;
    #1;
    check("stall_on_req", stall[k], 1'b1);
    for (int c = 1; c <= 12 && resp_at < 0; c++) begin
      @(negedge clk);
      if (mem_en[k]) begin
        issues++;
        if (issue_at < 0) begin
          issue_at = c; got_addr = mem_addr[k]; got_wdata = mem_wdata[k]; got_be = mem_be[k];
        end
      end
      if (resp_valid[k]) begin
        resp_at = c;
        got_rdata = resp_rdata[k];
        check("resp_misalign", resp_misalign[k], mis);
        check("stall_at_resp", stall[k], 1'b0);
      end else if (!stall[k]) begin
        stall_low++;
      end
      // Request fields wander while busy; the latched copy must be used.
      req_we[k] = 1'($urandom); req_size[k] = 2'($urandom); req_signed[k] = 1'($urandom);
      req_addr[k] = $urandom; req_wdata[k] = $urandom;
    end
    req_valid[k] = 1'b0;
    check("resp_cycle", resp_at, exp_resp);
    check("stall_low_cycles", stall_low, 0);
    check("mem_en_count", issues, mis ? 0 : 1);
    check("resp_rdata", got_rdata, v);
    if (!mis) begin
      check("issue_cycle", issue_at, 1);
      check("mem_addr", got_addr, {addr[31:2], 2'b00});
      check("mem_be", got_be, exp_be);
      if (we) check("mem_wdata", got_wdata, exp_wdata);
      if (we) for (int i = 0; i < nb; i++) ref_b[a+i] = 8'(exp_wdata >> (8*(nb-1-i)));
    end
    last_rdata[k] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, ad, wd;
    logic [3:0]  be;
    int          k;
    logic        we_r;
    logic [1:0]  sz_r;

    rst = 1'b1;
    req_valid = 3'b001; req_we = '0; req_signed = '0;
    for (int i = 0; i < N; i++) begin
      req_size[i] = '0; req_addr[i] = '0; req_wdata[i] = '0; last_rdata[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_stall_follows_req", stall[0], 1'b1);
    check("rst_resp_valid", resp_valid[0], 1'b0);
    check("rst_resp_misalign", resp_misalign[0], 1'b0);
    check("rst_mem_en", mem_en[0], 1'b0);
    check("rst_mem_be", mem_be[0], 4'b0000);
    check("rst_resp_rdata", resp_rdata[0], 32'h0);
    check("rst_mem_addr", mem_addr[0], 32'h0);
    check("rst_mem_wdata", mem_wdata[0], 32'h0);
    req_valid = '0;
    rst = 1'b0;

    // Fill memory with word stores so model and memory agree.
    for (int i = 0; i < 16; i++) txn(0, 1'b1, 2'b10, 1'b0, 32'h100 + 32'(4*i), $urandom, r, ad, wd, be);

    // Word load with latency 2.
    txn(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h1122_3344, r, ad, wd, be);
    txn(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, r, ad, wd, be);
    check("t1_lw_rdata", r, 32'h1122_3344);

    // Byte and half loads with extension.
    txn(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h1122_33F4, r, ad, wd, be);
    txn(0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, r, ad, wd, be);
    check("t2_lb_rdata", r, 32'hFFFF_FFF4);
    txn(0, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, r, ad, wd, be);
    check("t2_lbu_rdata", r, 32'h0000_00F4);
    txn(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h1122_F344, r, ad, wd, be);
    txn(0, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, r, ad, wd, be);
    check("t2_lh_rdata", r, 32'hFFFF_F344);

    // Byte and half stores.
    txn(0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AB, r, ad, wd, be);
    check("t3_sb_be", be, 4'b0100);
    check("t3_sb_wdata", wd, 32'hABAB_ABAB);
    check("t3_sb_addr", ad, 32'h100);
    txn(0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_BEEF, r, ad, wd, be);
    check("t3_sh_be", be, 4'b0011);

    // Misaligned word load.
    txn(0, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, r, ad, wd, be);
    check("t4_mis_rdata", r, 32'h0);

    // Reset while waiting on memory.
    @(negedge clk);
    req_we[0] = 1'b0; req_size[0] = 2'b10; req_signed[0] = 1'b0;
    req_addr[0] = 32'h104; req_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; req_valid[0] = 1'b0;
    @(negedge clk);
    check("t5_rst_resp_valid", resp_valid[0], 1'b0);
    check("t5_rst_mem_en", mem_en[0], 1'b0);
    check("t5_rst_resp_rdata", resp_rdata[0], 32'h0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) last_rdata[i] = '0;
    @(negedge clk);
    check("t5_no_late_resp", resp_valid[0], 1'b0);
    txn(0, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, r, ad, wd, be);

    // Back-to-back loads at latency 1 and 3.
    txn(1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, r, ad, wd, be);
    txn(1, 1'b0, 2'b00, 1'b1, 32'h10D, 32'h0, r, ad, wd, be);
    txn(2, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, r, ad, wd, be);
    txn(2, 1'b0, 2'b10, 1'b0, 32'h108, 32'h0, r, ad, wd, be);

    // Randomized traffic across all three latencies.
    for (int n = 0; n < 150; n++) begin
      k    = $urandom_range(0, N-1);
      we_r = 1'($urandom);
      sz_r = 2'($urandom);
      txn(k, we_r, sz_r, 1'($urandom), 32'h100 + 32'($urandom_range(0, 63)), $urandom,
          r, ad, wd, be);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
